// File: rtl/mpy_acc_pkg.sv
// Shared types and defaults for the multiplier result accumulator.
// Holds the FSM state enum, default parameters and the product sign-extender.
package mpy_acc_pkg;

  typedef enum logic {ACC, PUSH} state_e;

  localparam int DEF_ACC_W = 72;
  localparam int DEF_GROUP = 4;
  localparam int DEF_DEPTH = 4;
  localparam int EXT_W     = 128;

  // Wide enough for any ACC_W; callers size-cast down to ACC_W.
  function automatic logic [EXT_W-1:0] sext64(
    input logic [63:0] p
  );
    return {{(EXT_W-64){p[63]}}, p};
  endfunction

endpackage

// File: rtl/mpy_acc_fifo.sv
// Synchronous first-word-fall-through FIFO for group sums.
// Ports: CLK, RST, wr_en/wdata, rd_en, full, empty, rdata (registered head).
module mpy_acc_fifo #(
  parameter int W     = 72,
  parameter int DEPTH = 4
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         wr_en,
  input  logic [W-1:0] wdata,
  input  logic         rd_en,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] rdata
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wp, rp, wp_n, rp_n;
  logic         wr_ok, rd_ok;

  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW]) &&
                 (wp[AW-1:0] == rp[AW-1:0]);

  // A pop frees the slot the same-cycle push lands in.
  assign rd_ok = rd_en && !empty;
  assign wr_ok = wr_en && (!full || rd_ok);
  assign wp_n  = wp + (AW+1)'(wr_ok);
  assign rp_n  = rp + (AW+1)'(rd_ok);

  always_ff @(posedge CLK) begin
    if (wr_ok) mem[wp[AW-1:0]] <= wdata;
  end

  // Head register: bypass wdata when the new head is the slot
  // being written; hold the last value once empty.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wp    <= '0;
      rp    <= '0;
      rdata <= '0;
    end else begin
      wp <= wp_n;
      rp <= rp_n;
      if (wp_n != rp_n) begin
        if (wr_ok && rp_n[AW-1:0] == wp[AW-1:0])
          rdata <= wdata;
        else
          rdata <= mem[rp_n[AW-1:0]];
      end
    end
  end

endmodule

// File: rtl/mpy_result_acc.sv
// Sums GROUP signed 64-bit products into ACC_W-bit group sums and queues them.
// Ports: CLK, RST, Product/Product_Valid, clr_acc, out_ready/out_valid/out_data,
// fifo_full, drop_cnt, sat_flag. Macro MPY_ACC_SAT_EN enables saturating adds.
module mpy_result_acc
  import mpy_acc_pkg::*;
#(
  parameter int ACC_W = DEF_ACC_W,
  parameter int GROUP = DEF_GROUP,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [63:0]      Product,
  input  logic             Product_Valid,
  input  logic             clr_acc,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [ACC_W-1:0] out_data,
  output logic             fifo_full,
  output logic [7:0]       drop_cnt,
  output logic             sat_flag
);

  localparam int CW = $clog2(GROUP + 1);

  state_e           state, state_n;
  logic [ACC_W-1:0] acc, acc_n, sum_reg;
  logic [ACC_W-1:0] base, addend, sum;
  logic [CW-1:0]    cnt, cnt_n, base_cnt, cnt_inc;
  logic             sum_ld, push, drop, empty;

  assign push      = (state == PUSH);
  assign drop      = push && fifo_full && !out_ready;
  assign out_valid = !empty;

  // Clear takes effect before a same-cycle product.
  always_comb begin
    base     = clr_acc ? '0 : acc;
    base_cnt = clr_acc ? '0 : cnt;
    addend   = ACC_W'(sext64(Product));
    cnt_inc  = base_cnt + CW'(1);
  end

`ifdef MPY_ACC_SAT_EN
  logic [ACC_W:0] wide;
  logic           sat_hit;

  always_comb begin
    wide    = {base[ACC_W-1], base} +
              {addend[ACC_W-1], addend};
    sum     = wide[ACC_W-1:0];
    sat_hit = 1'b0;
    if (wide[ACC_W] != wide[ACC_W-1]) begin
      sat_hit = Product_Valid;
      sum = wide[ACC_W] ?
            {1'b1, {(ACC_W-1){1'b0}}} :
            {1'b0, {(ACC_W-1){1'b1}}};
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)          sat_flag <= 1'b0;
    else if (sat_hit) sat_flag <= 1'b1;
  end
`else
  always_comb sum = base + addend;
  assign sat_flag = 1'b0;
`endif

  always_comb begin
    state_n = ACC;
    acc_n   = base;
    cnt_n   = base_cnt;
    sum_ld  = 1'b0;
    if (Product_Valid) begin
      if (cnt_inc == CW'(GROUP)) begin
        sum_ld  = 1'b1;
        acc_n   = '0;
        cnt_n   = '0;
        state_n = PUSH;
      end else begin
        acc_n = sum;
        cnt_n = cnt_inc;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= ACC;
    else     state <= state_n;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      acc      <= '0;
      cnt      <= '0;
      sum_reg  <= '0;
      drop_cnt <= '0;
    end else begin
      acc <= acc_n;
      cnt <= cnt_n;
      if (sum_ld) sum_reg <= sum;
      if (drop && drop_cnt != 8'hFF)
        drop_cnt <= drop_cnt + 8'd1;
    end
  end

  mpy_acc_fifo #(
    .W     (ACC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .wr_en (push),
    .wdata (sum_reg),
    .rd_en (out_ready),
    .full  (fifo_full),
    .empty (empty),
    .rdata (out_data)
  );

endmodule

// File: tb/tb_mpy_result_acc.sv
// Directed bench for mpy_result_acc (72-bit default plus a 64-bit instance).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_mpy_result_acc;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [63:0] Product = '0;
  logic        Product_Valid = 1'b0;
  logic        clr_acc = 1'b0;
  logic        out_ready = 1'b0;

  logic        out_valid, fifo_full, sat_flag;
  logic [71:0] out_data;
  logic [7:0]  drop_cnt;

  logic        v64, full64, sat64;
  logic [63:0] d64;
  logic [7:0]  drop64;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  mpy_result_acc #(.ACC_W(72), .GROUP(4), .DEPTH(4)) dut (
    .CLK(CLK), .RST(RST), .Product(Product),
    .Product_Valid(Product_Valid), .clr_acc(clr_acc),
    .out_ready(out_ready), .out_valid(out_valid),
    .out_data(out_data), .fifo_full(fifo_full),
    .drop_cnt(drop_cnt), .sat_flag(sat_flag)
  );

  mpy_result_acc #(.ACC_W(64), .GROUP(4), .DEPTH(4)) dut64 (
    .CLK(CLK), .RST(RST), .Product(Product),
    .Product_Valid(Product_Valid), .clr_acc(clr_acc),
    .out_ready(out_ready), .out_valid(v64),
    .out_data(d64), .fifo_full(full64),
    .drop_cnt(drop64), .sat_flag(sat64)
  );

  task automatic send(input logic [63:0] p, input logic c = 1'b0);
    Product = p;
    Product_Valid = 1'b1;
    clr_acc = c;
    @(negedge CLK);
    Product_Valid = 1'b0;
    clr_acc = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic do_reset();
    out_ready = 1'b0;
    Product_Valid = 1'b0;
    clr_acc = 1'b0;
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++;
      $display("FAIL rst_valid got %0h want 0", out_valid); end
    n_cmp++; if (out_data !== 72'h0) begin n_bad++;
      $display("FAIL rst_data got %0h want 0", out_data); end
    n_cmp++; if (fifo_full !== 1'b0) begin n_bad++;
      $display("FAIL rst_full got %0h want 0", fifo_full); end
    n_cmp++; if (drop_cnt !== 8'h0) begin n_bad++;
      $display("FAIL rst_drop got %0h want 0", drop_cnt); end
    n_cmp++; if (sat_flag !== 1'b0) begin n_bad++;
      $display("FAIL rst_sat got %0h want 0", sat_flag); end
    n_cmp++; if (v64 !== 1'b0 || d64 !== 64'h0) begin n_bad++;
      $display("FAIL rst_d64 got %0h/%0h want 0/0", v64, d64); end
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    send(64'd3); send(-64'sd5); send(64'd10); send(64'd7);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++;
      $display("FAIL basic_push_cycle valid got %0h want 0", out_valid); end
    idle(1);
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++;
      $display("FAIL basic_valid got %0h want 1", out_valid); end
    n_cmp++; if (out_data !== 72'd15) begin n_bad++;
      $display("FAIL basic_data got %0h want f", out_data); end
    idle(1);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++;
      $display("FAIL basic_popped valid got %0h want 0", out_valid); end
    n_cmp++; if (out_data !== 72'd15) begin n_bad++;
      $display("FAIL basic_hold got %0h want f", out_data); end
  endtask

  task automatic test_wide();
    out_ready = 1'b1;
    repeat (4) send(64'h3FFF_FFFF_FFFF_FFFF);
    idle(1);
    n_cmp++; if (out_data !== 72'h00_FFFF_FFFF_FFFF_FFFC) begin n_bad++;
      $display("FAIL wide_pos got %0h want fffffffffffffffc", out_data); end
    idle(1);
    repeat (4) send(64'h8000_0000_0000_0000);
    idle(1);
    n_cmp++; if (out_data !== 72'hFE_0000_0000_0000_0000) begin n_bad++;
      $display("FAIL wide_neg got %0h want fe0000000000000000", out_data); end
    idle(1);
  endtask

  task automatic test_overflow_fifo();
    logic [71:0] exp_d [4] = '{72'd4, 72'd8, 72'd12, 72'd16};
    do_reset();
    for (int g = 1; g <= 5; g++)
      repeat (4) send(64'(g));
    idle(1);
    n_cmp++; if (fifo_full !== 1'b1) begin n_bad++;
      $display("FAIL ovf_full got %0h want 1", fifo_full); end
    n_cmp++; if (drop_cnt !== 8'd1) begin n_bad++;
      $display("FAIL ovf_drop got %0d want 1", drop_cnt); end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (out_valid !== 1'b1 || out_data !== exp_d[i]) begin
        n_bad++;
        $display("FAIL ovf_drain%0d got %0h/%0h want 1/%0h",
                 i, out_valid, out_data, exp_d[i]);
      end
      idle(1);
    end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++;
      $display("FAIL ovf_empty valid got %0h want 0", out_valid); end
  endtask

  task automatic test_pop_during_push();
    logic [71:0] exp_d [4] = '{72'd8, 72'd12, 72'd16, 72'd20};
    do_reset();
    for (int g = 1; g <= 4; g++)
      repeat (4) send(64'(g));
    idle(1);
    repeat (4) send(64'd5);
    out_ready = 1'b1;
    idle(1);
    out_ready = 1'b0;
    n_cmp++; if (drop_cnt !== 8'd0) begin n_bad++;
      $display("FAIL pp_drop got %0d want 0", drop_cnt); end
    n_cmp++; if (fifo_full !== 1'b1) begin n_bad++;
      $display("FAIL pp_full got %0h want 1", fifo_full); end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (out_data !== exp_d[i]) begin n_bad++;
        $display("FAIL pp_drain%0d got %0h want %0h",
                 i, out_data, exp_d[i]);
      end
      idle(1);
    end
  endtask

  task automatic test_clear();
    do_reset();
    out_ready = 1'b1;
    send(64'd9); send(64'd9);
    send(64'd1, 1'b1);
    send(64'd2); send(64'd3); send(64'd4);
    idle(1);
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 72'd10) begin
      n_bad++;
      $display("FAIL clr_data got %0h/%0h want 1/a", out_valid, out_data);
    end
    idle(1);
  endtask

  task automatic test_async_reset();
    do_reset();
    repeat (4) send(64'd5);
    idle(1);
    n_cmp++; if (out_data !== 72'd20) begin n_bad++;
      $display("FAIL ar_pre got %0h want 14", out_data); end
    send(64'd7); send(64'd7);
    #3 RST = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || out_data !== 72'h0) begin
      n_bad++;
      $display("FAIL ar_now got %0h/%0h want 0/0", out_valid, out_data);
    end
    @(negedge CLK);
    RST = 1'b0;
    out_ready = 1'b1;
    repeat (4) send(64'd1);
    idle(1);
    n_cmp++; if (out_data !== 72'd4) begin n_bad++;
      $display("FAIL ar_post got %0h want 4", out_data); end
    idle(1);
  endtask

  task automatic test_saturate();
    do_reset();
    out_ready = 1'b1;
    repeat (4) send(64'h4000_0000_0000_0000);
    idle(1);
    n_cmp++; if (out_data !== 72'h01_0000_0000_0000_0000) begin
      n_bad++;
      $display("FAIL sat_w72 got %0h want 10000000000000000", out_data);
    end
    n_cmp++; if (sat_flag !== 1'b0) begin n_bad++;
      $display("FAIL sat_flag72 got %0h want 0", sat_flag); end
`ifdef MPY_ACC_SAT_EN
    n_cmp++; if (d64 !== 64'h7FFF_FFFF_FFFF_FFFF) begin n_bad++;
      $display("FAIL sat_d64 got %0h want 7fffffffffffffff", d64); end
    n_cmp++; if (sat64 !== 1'b1) begin n_bad++;
      $display("FAIL sat_flag64 got %0h want 1", sat64); end
`else
    n_cmp++; if (v64 !== 1'b1 || d64 !== 64'h0) begin n_bad++;
      $display("FAIL wrap_d64 got %0h/%0h want 1/0", v64, d64); end
    n_cmp++; if (sat64 !== 1'b0) begin n_bad++;
      $display("FAIL wrap_flag64 got %0h want 0", sat64); end
`endif
    idle(1);
  endtask

  initial begin
    @(negedge CLK);
    test_reset();
    test_basic();
    test_wide();
    test_overflow_fifo();
    test_pop_during_push();
    test_clear();
    test_async_reset();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
